traffic_light_monitor: RTL
==========================

Name: traffic_light_monitor

Overview:
- Passive checker that sits on the output side of the traffic controller and watches its lamp buses.
- Tracks the phase sequence and dwell time of each phase, and confirms that road and pedestrian lamps never conflict.
- Latches the first violation as a sticky fault with a code, and counts completed road cycles.
- Used in simulation benches and as an on-board safety watchdog driving a fault LED.

Parameters:
- MIN_GREEN, 8: minimum consecutive cycles light1 must hold green before going yellow.
- MIN_YELLOW, 2: minimum consecutive cycles light1 must hold yellow before going red.
- CNT_W, 16: width of the dwell counter and of cycle_count.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- on  in  1  controller enable, same signal that feeds the controller.
- light1  in  3  road lamps {red,yellow,green}; legal values are 100, 010, 001.
- light2  in  2  pedestrian lamps {dont_walk,walk}; legal values are 10, 01.
- clr  in  1  clears a latched fault; single-cycle pulse.
- fault  out  1  sticky violation flag.
- fault_code  out  3  code of the first violation; 0 means none.
- cycle_done  out  1  one-cycle pulse per completed G->Y->R->G cycle.
- cycle_count  out  CNT_W  number of completed cycles; saturates at all-ones.

Behaviour:
- Reset and clock:
  - Synchronous rst on posedge clk.
  - Reset values: fault=0, fault_code=0, cycle_done=0, cycle_count=0.
  - Reset values: state=OFF, dwell=0, partial=1, off_grace=1.
- Latency: checks use the inputs sampled at edge N. fault, fault_code and cycle_done reflect that sample right after edge N (1-cycle registered latency).
- FSM states: OFF, RED, GREEN, YELLOW, FAULT.
  - OFF, on=1:
    - Go to RED, GREEN or YELLOW according to legal light1.
    - Set partial=1 and dwell=1.
  - RED/GREEN/YELLOW, light1 unchanged: dwell += 1, saturating.
  - GREEN->YELLOW:
    - Check dwell>=MIN_GREEN, skipped if partial.
    - Then dwell=1, partial=0.
  - YELLOW->RED:
    - Check dwell>=MIN_YELLOW, skipped if partial.
    - Then dwell=1, partial=0.
  - RED->GREEN:
    - dwell=1.
    - If partial=0 and a full G,Y,R sequence was seen: pulse cycle_done and increment cycle_count.
    - Then partial=0.
  - Any other light1 change (G->R, R->Y, Y->G): illegal transition.
  - on falls: go to OFF; grace flag off_grace=1 for one cycle.
  - FAULT: hold everything until clr or rst.
- Violation codes (checked only outside FAULT):
  - 1: light1 or light2 not one-hot while on=1.
  - 2: conflict, light2=01 while light1 is green or yellow.
  - 3: illegal light1 transition.
  - 4: short green.
  - 5: short yellow.
  - 6: on=0 and lamps are not 000/00 after the grace cycle.
  - Several in the same cycle: the lowest code wins.
  - Any violation sets fault=1, latches fault_code, and moves the FSM to FAULT. The code is never overwritten.
- clr:
  - Clears fault and fault_code, goes to OFF with partial=1.
  - A violation in the same cycle as clr is ignored; clr wins.
  - cycle_count is kept.
- Counters: dwell saturates at 2^CNT_W-1, so a long hold never wraps into a false short-phase check.
- rst mid-cycle: full return to reset values; the next phase is treated as partial.

Decomposition:
- Shared package traffic_pkg holds:
  - Lamp encodings L1_RED=3'b100, L1_YEL=3'b010, L1_GRN=3'b001, L2_STOP=2'b10, L2_WALK=2'b01.
  - Monitor state encoding.
  - Fault code constants FC_NONE..FC_OFF_ACTIVE.
  - The package is shared with the controller.
- One natural sub-module: sat_counter (parameterised width, synchronous clear/load/increment, saturating). It is instantiated for dwell and for cycle_count.

Test Plan:
1. Legal run, MIN_GREEN=8, MIN_YELLOW=2: on=1; sequence R(5)->G(8)->Y(2)->R(5)->G -> cycle_done pulses once at the second G sample; cycle_count=1; fault stays 0.
2. Short yellow: after a full phase, G(8)->Y(1)->R -> fault=1 and fault_code=5 one cycle after R is sampled; the FSM ignores later inputs.
3. Conflict: light1=001 with light2=01 -> fault_code=2. Add a simultaneous illegal light1=011 -> fault_code=1, lowest code wins.
4. Illegal transition G->R directly -> fault_code=3. Then clr pulse -> fault=0, fault_code=0, and a later legal start produces no fault from a partial first phase of 3 cycles.
5. on drop: on=0 with lamps still 100 for exactly 1 cycle -> no fault. Hold for a 2nd cycle -> fault_code=6.
6. rst asserted mid-GREEN while fault=1 and cycle_count=3 -> all outputs 0 on the next edge. clr and a violation in the same cycle -> fault remains 0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Lamp encodings, monitor states and fault codes shared by the traffic
// controller and its monitor.
package traffic_pkg;

    localparam logic [2:0] L1_OFF = 3'b000;
    localparam logic [2:0] L1_RED = 3'b100;
    localparam logic [2:0] L1_YEL = 3'b010;
    localparam logic [2:0] L1_GRN = 3'b001;

    localparam logic [1:0] L2_OFF  = 2'b00;
    localparam logic [1:0] L2_STOP = 2'b10;
    localparam logic [1:0] L2_WALK = 2'b01;

    typedef enum logic [2:0] {
        MON_OFF    = 3'd0,
        MON_RED    = 3'd1,
        MON_GREEN  = 3'd2,
        MON_YELLOW = 3'd3,
        MON_FAULT  = 3'd4
    } mon_state_e;

    localparam logic [2:0] FC_NONE          = 3'd0;
    localparam logic [2:0] FC_NOT_ONEHOT    = 3'd1;
    localparam logic [2:0] FC_CONFLICT      = 3'd2;
    localparam logic [2:0] FC_ILLEGAL_TRANS = 3'd3;
    localparam logic [2:0] FC_SHORT_GREEN   = 3'd4;
    localparam logic [2:0] FC_SHORT_YELLOW  = 3'd5;
    localparam logic [2:0] FC_OFF_ACTIVE    = 3'd6;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, load and increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    // Clear beats load beats increment; the count sticks at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive watchdog on the traffic controller lamp buses: checks phase order,
// minimum dwell and lamp conflicts, latches the first fault, counts cycles.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN  = 8,
    parameter int MIN_YELLOW = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic [2:0]       light1,
    input  logic [1:0]       light2,
    input  logic             clr,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic             cycle_done,
    output logic [CNT_W-1:0] cycle_count
);

    mon_state_e state_q, state_d;
    logic       partial_q, partial_d;
    logic       off_grace_q, off_grace_d;
    logic       seq_q, seq_d;
    logic       fault_q, fault_d;
    logic [2:0] code_q, code_d;
    logic       done_q, done_d;

    logic [CNT_W-1:0] dwell;
    logic             dwell_clr, dwell_load, dwell_inc;
    logic             cnt_inc;

    mon_state_e lamp_state;
    logic       l1_legal, l2_legal, running, changed, legal_step;
    logic [2:0] viol;

    sat_counter #(.W(CNT_W)) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (dwell_clr),
        .load_i     (dwell_load),
        .load_val_i (CNT_W'(1)),
        .inc_i      (dwell_inc),
        .count_o    (dwell)
    );

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (1'b0),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (cnt_inc),
        .count_o    (cycle_count)
    );

    always_comb begin
        lamp_state = MON_OFF;
        case (light1)
            L1_RED:  lamp_state = MON_RED;
            L1_YEL:  lamp_state = MON_YELLOW;
            L1_GRN:  lamp_state = MON_GREEN;
            default: lamp_state = MON_OFF;
        endcase
        l1_legal   = (light1 == L1_RED) || (light1 == L1_YEL) || (light1 == L1_GRN);
        l2_legal   = (light2 == L2_STOP) || (light2 == L2_WALK);
        running    = (state_q == MON_RED) || (state_q == MON_GREEN) || (state_q == MON_YELLOW);
        changed    = running && (lamp_state != state_q);
        legal_step = ((state_q == MON_GREEN)  && (lamp_state == MON_YELLOW)) ||
                     ((state_q == MON_YELLOW) && (lamp_state == MON_RED))    ||
                     ((state_q == MON_RED)    && (lamp_state == MON_GREEN));
    end

    // Ordered lowest code first so the smallest applicable code is reported.
    always_comb begin
        viol = FC_NONE;
        if (on && (!l1_legal || !l2_legal)) begin
            viol = FC_NOT_ONEHOT;
        end else if (on && (light2 == L2_WALK) && ((light1 == L1_GRN) || (light1 == L1_YEL))) begin
            viol = FC_CONFLICT;
        end else if (on && changed && !legal_step) begin
            viol = FC_ILLEGAL_TRANS;
        end else if (on && (state_q == MON_GREEN) && (lamp_state == MON_YELLOW) &&
                     !partial_q && (dwell < CNT_W'(MIN_GREEN))) begin
            viol = FC_SHORT_GREEN;
        end else if (on && (state_q == MON_YELLOW) && (lamp_state == MON_RED) &&
                     !partial_q && (dwell < CNT_W'(MIN_YELLOW))) begin
            viol = FC_SHORT_YELLOW;
        end else if (!on && !off_grace_q && ((light1 != L1_OFF) || (light2 != L2_OFF))) begin
            viol = FC_OFF_ACTIVE;
        end
    end

    always_comb begin
        state_d     = state_q;
        partial_d   = partial_q;
        off_grace_d = off_grace_q;
        seq_d       = seq_q;
        fault_d     = fault_q;
        code_d      = code_q;
        done_d      = 1'b0;
        dwell_clr   = 1'b0;
        dwell_load  = 1'b0;
        dwell_inc   = 1'b0;
        cnt_inc     = 1'b0;

        if (clr) begin
            state_d     = MON_OFF;
            partial_d   = 1'b1;
            off_grace_d = 1'b1;
            seq_d       = 1'b0;
            fault_d     = 1'b0;
            code_d      = FC_NONE;
            dwell_clr   = 1'b1;
        end else if (state_q == MON_FAULT) begin
            state_d = MON_FAULT;
        end else if (viol != FC_NONE) begin
            state_d = MON_FAULT;
            fault_d = 1'b1;
            code_d  = viol;
        end else if (!on) begin
            state_d     = MON_OFF;
            partial_d   = 1'b1;
            off_grace_d = 1'b0;
            seq_d       = 1'b0;
            dwell_clr   = 1'b1;
        end else begin
            off_grace_d = 1'b1;
            if (state_q == MON_OFF) begin
                state_d    = lamp_state;
                partial_d  = 1'b1;
                seq_d      = 1'b0;
                dwell_load = 1'b1;
            end else if (lamp_state == state_q) begin
                dwell_inc = 1'b1;
            end else begin
                // seq_q marks a fully observed green; the cycle only counts
                // once that green has been followed by yellow and red.
                state_d    = lamp_state;
                partial_d  = 1'b0;
                dwell_load = 1'b1;
                if (state_q == MON_GREEN) begin
                    seq_d = !partial_q;
                end else if (state_q == MON_RED) begin
                    if (!partial_q && seq_q) begin
                        done_d  = 1'b1;
                        cnt_inc = 1'b1;
                    end
                    seq_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MON_OFF;
            partial_q   <= 1'b1;
            off_grace_q <= 1'b1;
            seq_q       <= 1'b0;
            fault_q     <= 1'b0;
            code_q      <= FC_NONE;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            partial_q   <= partial_d;
            off_grace_q <= off_grace_d;
            seq_q       <= seq_d;
            fault_q     <= fault_d;
            code_q      <= code_d;
            done_q      <= done_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign cycle_done = done_q;

endmodule
